dbg_probe: RTL
==============

Name: dbg_probe

Overview:
Debug-port initiator for the single-cycle core.
- Drives the core's read-only debug request ports: regfile_req_dbg, and datamem_addr_dbg.
- Captures regfile_data_dbg / datamem_data_dbg and returns them to a host-side command interface as single reads or bursts.
- Sits between the board-level host logic (buttons/UART bridge/display mux) and the core top.

Parameters:
- RD_LAT, 1, cycles the debug address is held stable before data is sampled (1..15).
- BURST_W, 8, width of the burst-length field (beats = cmd_len+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  block can accept a command
- cmd_sel  in  1  target: 0 = register file, 1 = data memory
- cmd_addr  in  32  start address; RF uses [4:0], DM is a byte address
- cmd_len  in  BURST_W  beats minus one
- rsp_valid  out  1  response beat valid
- rsp_ready  in  1  host accepts beat
- rsp_data  out  32  captured debug data
- rsp_addr  out  32  address the beat was read from
- rsp_last  out  1  final beat of burst
- busy  out  1  command in progress
- regfile_req_dbg  out  5  to core RF debug port
- datamem_addr_dbg  out  32  to core DM debug port
- regfile_data_dbg  in  32  from core
- datamem_data_dbg  in  32  from core

Behaviour:
- All state changes are on the rising edge of clk. rst is synchronous active-high.
- Reset values:
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_last=0.
  - rsp_data=0, rsp_addr=0.
  - regfile_req_dbg=0, datamem_addr_dbg=0.
  - FSM=IDLE, beat counter=0, latency counter=0.
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&cmd_ready, latch sel and len, load the address, go to SETTLE.
  - RF: regfile_req_dbg<=cmd_addr[4:0].
  - DM: datamem_addr_dbg<={cmd_addr[31:2],2'b00}; the low 2 bits are always forced to 0.
  - The unused debug address output keeps its previous value.
- SETTLE:
  - cmd_ready=0, busy=1. The latency counter counts RD_LAT cycles.
  - On the last settle cycle, capture the selected data into rsp_data and the current address into rsp_addr.
  - rsp_last=(beat counter==len). Set rsp_valid=1, go to HOLD.
- Latency: accept at edge N; first rsp_valid is high from edge N+RD_LAT+1. With RD_LAT=1, rsp_valid rises 2 cycles after the accept edge.
- HOLD:
  - rsp_valid, rsp_data, rsp_addr and rsp_last are held stable until rsp_ready.
  - On rsp_valid&rsp_ready with rsp_last=0: increment the address, increment the beat counter, clear rsp_valid, go to SETTLE.
    - RF address increments by 1 modulo 32 (31 wraps to 0).
    - DM address increments by 4 modulo 2^32 (0xFFFFFFFC wraps to 0).
  - On rsp_valid&rsp_ready with rsp_last=1: clear rsp_valid and rsp_last, go to IDLE. cmd_ready returns to 1 the next cycle; there is no same-cycle command re-accept.
- rsp_ready while rsp_valid=0 is ignored.
- Throughput: at most one beat per RD_LAT+1 cycles, given rsp_ready=1.
- cmd_len=0 is a single read. cmd_len=all-ones gives 2^BURST_W beats. An RF burst longer than 32 wraps and repeats registers.
- Commands presented while busy are not accepted; cmd_ready stays 0.
- Reset mid-burst aborts immediately; all outputs return to reset values on the next edge and no further beats are emitted.
- The debug data inputs are sampled only on the capture edge; changes at any other time have no effect.

Optional Feature:
- Macro: DBG_PROBE_CKSUM_EN.
- Defined:
  - A 32-bit running XOR of every captured beat in the burst is kept, cleared on command accept.
  - After the last data beat is accepted, one extra beat is emitted 1 cycle later: rsp_data=checksum, rsp_addr=32'hFFFFFFFF, rsp_last=1.
  - In this build, data beats never set rsp_last.
  - The extra beat follows the normal HOLD handshake.
- Undefined: no checksum logic or extra beat; the last data beat carries rsp_last=1.

Test Plan:
- Reset, then RF read: cmd_sel=0, cmd_addr=2, len=0, core $2=0x00000005 → regfile_req_dbg=2; rsp_valid 2 cycles after accept; rsp_data=0x5, rsp_addr=2, rsp_last=1; cmd_ready=1 one cycle after the handshake.
- DM burst: cmd_sel=1, cmd_addr=0x13 (misaligned), len=2, memory words at 0x10/0x14/0x18 = A/B/C → beats (0x10,A), (0x14,B), (0x18,C,last). datamem_addr_dbg never has bits [1:0]≠0.
- RF wrap: cmd_addr=30, len=3 → rsp_addr sequence 30, 31, 0, 1. The beat from $0 returns 0.
- Backpressure: hold rsp_ready=0 for 5 cycles mid-burst → rsp_valid stays high with data/addr stable; datamem_addr_dbg unchanged; cmd_valid pulses during the burst are not accepted.
- Reset mid-burst: assert rst during SETTLE of beat 2 → next edge rsp_valid=0, busy=0, cmd_ready=1; debug addresses are 0.
- With DBG_PROBE_CKSUM_EN: DM burst of words 0x0F0F0F0F and 0x00FF00FF → data beats with rsp_last=0, then checksum beat 0x0FF00FF0, rsp_addr=0xFFFFFFFF, rsp_last=1.

Source files
------------

// File: rtl/dbg_probe.sv
// Debug-port initiator: reads the core's register file / data memory debug ports
// as single reads or bursts. Define DBG_PROBE_CKSUM_EN to append an XOR checksum beat.
module dbg_probe #(
   parameter int RD_LAT  = 1,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic               cmd_sel,
   input  logic [31:0]        cmd_addr,
   input  logic [BURST_W-1:0] cmd_len,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [31:0]        rsp_data,
   output logic [31:0]        rsp_addr,
   output logic               rsp_last,
   output logic               busy,
   output logic [4:0]         regfile_req_dbg,
   output logic [31:0]        datamem_addr_dbg,
   input  logic [31:0]        regfile_data_dbg,
   input  logic [31:0]        datamem_data_dbg
);

`ifdef DBG_PROBE_CKSUM_EN
   typedef enum logic [1:0] {IDLE, SETTLE, HOLD, CKSUM} state_t;
`else
   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
`endif

   localparam logic [3:0] LAT_TOP = 4'(RD_LAT);

   state_t             state, state_nxt;
   logic               sel_q;
   logic [BURST_W-1:0] len_q;
   logic [BURST_W-1:0] beat_cnt;
   logic [3:0]         lat_cnt;
   logic               accept, capture, fire, advance, last_data;
   logic [31:0]        sel_data;
`ifdef DBG_PROBE_CKSUM_EN
   logic [31:0]        cksum;
`endif

   function automatic logic [4:0] next_rf_addr(input logic [4:0] a);
      return a + 5'd1;
   endfunction

   function automatic logic [31:0] next_dm_addr(input logic [31:0] a);
      return a + 32'd4;
   endfunction

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      capture   = 1'b0;
      fire      = 1'b0;
      advance   = 1'b0;
      last_data = (beat_cnt == len_q);
      sel_data  = sel_q ? datamem_data_dbg : regfile_data_dbg;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            accept    = cmd_valid;
            if (cmd_valid) state_nxt = SETTLE;
         end
         SETTLE: begin
            capture = (lat_cnt == LAT_TOP);
            if (capture) state_nxt = HOLD;
         end
         HOLD: begin
            fire = rsp_valid & rsp_ready;
            if (fire) begin
               if (rsp_last) begin
                  state_nxt = IDLE;
`ifdef DBG_PROBE_CKSUM_EN
               end else if (last_data) begin
                  state_nxt = CKSUM;
`endif
               end else begin
                  advance   = 1'b1;
                  state_nxt = SETTLE;
               end
            end
         end
`ifdef DBG_PROBE_CKSUM_EN
         CKSUM: state_nxt = HOLD;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // First beat settles RD_LAT+1 cycles after accept; later beats reload the
   // counter at 1 so a burst streams one beat per RD_LAT+1 cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         sel_q            <= 1'b0;
         len_q            <= '0;
         beat_cnt         <= '0;
         lat_cnt          <= '0;
         rsp_valid        <= 1'b0;
         rsp_last         <= 1'b0;
         rsp_data         <= '0;
         rsp_addr         <= '0;
         regfile_req_dbg  <= '0;
         datamem_addr_dbg <= '0;
`ifdef DBG_PROBE_CKSUM_EN
         cksum            <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (accept) begin
            sel_q    <= cmd_sel;
            len_q    <= cmd_len;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            if (cmd_sel) datamem_addr_dbg <= {cmd_addr[31:2], 2'b00};
            else         regfile_req_dbg  <= cmd_addr[4:0];
`ifdef DBG_PROBE_CKSUM_EN
            cksum    <= '0;
`endif
         end
         if (state == SETTLE && !capture) lat_cnt <= lat_cnt + 4'd1;
         if (capture) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sel_data;
            rsp_addr  <= sel_q ? datamem_addr_dbg : {27'd0, regfile_req_dbg};
`ifdef DBG_PROBE_CKSUM_EN
            rsp_last  <= 1'b0;
            cksum     <= cksum ^ sel_data;
`else
            rsp_last  <= last_data;
`endif
         end
         if (fire) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
         end
         if (advance) begin
            beat_cnt <= beat_cnt + BURST_W'(1);
            lat_cnt  <= 4'd1;
            if (sel_q) datamem_addr_dbg <= next_dm_addr(datamem_addr_dbg);
            else       regfile_req_dbg  <= next_rf_addr(regfile_req_dbg);
         end
`ifdef DBG_PROBE_CKSUM_EN
         if (state == CKSUM) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cksum;
            rsp_addr  <= 32'hFFFF_FFFF;
            rsp_last  <= 1'b1;
         end
`endif
      end
   end

endmodule
